// File: rtl/riscv_regfile_sb.sv
// RISC-V integer register file with a per-register pending scoreboard and an
// optional write-back bypass onto the combinational read ports.
module riscv_regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [NUM_RD-1:0]              rd_en_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]              rd_busy_o,
  output logic                           hazard_o,
  input  logic                           issue_en_i,
  input  logic [ADDR_WIDTH-1:0]          issue_addr_i,
  input  logic                           wr_en_i,
  input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           flush_i,
  output logic [ADDR_WIDTH:0]            pending_cnt_o
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [NumRegs-1:0]    pending_q, pending_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_ok, iss_ok, cnt_inc, cnt_dec;
  logic [ADDR_WIDTH-1:0] rd_a;

  assign wr_ok  = wr_en_i && (wr_addr_i != '0);
  // Flush drops any issue presented in the same cycle.
  assign iss_ok = issue_en_i && (issue_addr_i != '0) && !flush_i;

  always_comb begin
    pending_d = pending_q;
    if (wr_ok)   pending_d[wr_addr_i]    = 1'b0;
    if (iss_ok)  pending_d[issue_addr_i] = 1'b1;
    if (flush_i) pending_d = '0;
  end

  // A write-back only frees a slot if it clears a set bit that is not re-issued.
  always_comb begin
    cnt_inc = iss_ok && !pending_q[issue_addr_i];
    cnt_dec = wr_ok && pending_q[wr_addr_i] && !(iss_ok && (issue_addr_i == wr_addr_i));
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, cnt_inc} - {{ADDR_WIDTH{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) regs_q[r] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_a      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (rd_a != '0) begin
        if (BYPASS && wr_en_i && (wr_addr_i == rd_a)) begin
          rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_i;
          rd_busy_o[i]                          = 1'b0;
        end else begin
          rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_a];
          rd_busy_o[i]                          = pending_q[rd_a];
        end
      end
    end
  end

  assign hazard_o      = |(rd_en_i & rd_busy_o);
  assign pending_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Bench for riscv_regfile_sb: a default (bypassing) instance and a 4-port, 16-entry,
// 64-bit non-bypassing instance, each checked every cycle against an array model.
module tb_riscv_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A: defaults (32-bit, 32 regs, 2 ports, bypass)
  logic [9:0]  a_rd_addr;
  logic [1:0]  a_rd_en;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_hazard, a_issue_en, a_wr_en, a_flush;
  logic [4:0]  a_issue_addr, a_wr_addr;
  logic [31:0] a_wr_data;
  logic [5:0]  a_cnt;

  // Instance B: 64-bit, 16 regs, 4 ports, no bypass
  logic [15:0]  b_rd_addr;
  logic [3:0]   b_rd_en;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_hazard, b_issue_en, b_wr_en, b_flush;
  logic [3:0]   b_issue_addr, b_wr_addr;
  logic [63:0]  b_wr_data;
  logic [4:0]   b_cnt;

  riscv_regfile_sb u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_addr_i    (a_rd_addr),
    .rd_en_i      (a_rd_en),
    .rd_data_o    (a_rd_data),
    .rd_busy_o    (a_rd_busy),
    .hazard_o     (a_hazard),
    .issue_en_i   (a_issue_en),
    .issue_addr_i (a_issue_addr),
    .wr_en_i      (a_wr_en),
    .wr_addr_i    (a_wr_addr),
    .wr_data_i    (a_wr_data),
    .flush_i      (a_flush),
    .pending_cnt_o(a_cnt)
  );

  riscv_regfile_sb #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(4),
    .NUM_RD    (4),
    .BYPASS    (1'b0)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_addr_i    (b_rd_addr),
    .rd_en_i      (b_rd_en),
    .rd_data_o    (b_rd_data),
    .rd_busy_o    (b_rd_busy),
    .hazard_o     (b_hazard),
    .issue_en_i   (b_issue_en),
    .issue_addr_i (b_issue_addr),
    .wr_en_i      (b_wr_en),
    .wr_addr_i    (b_wr_addr),
    .wr_data_i    (b_wr_data),
    .flush_i      (b_flush),
    .pending_cnt_o(b_cnt)
  );

  // Reference state: register contents and pending flags per architectural register.
  logic [31:0] ma_reg  [32];
  bit          ma_pend [32];
  logic [63:0] mb_reg  [16];
  bit          mb_pend [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin ma_reg[i] <= '0; ma_pend[i] <= 1'b0; end
      for (int i = 0; i < 16; i++) begin mb_reg[i] <= '0; mb_pend[i] <= 1'b0; end
    end else begin
      if (a_wr_en && a_wr_addr != 0) begin
        ma_reg[a_wr_addr] <= a_wr_data;
        ma_pend[a_wr_addr] <= 1'b0;
      end
      if (a_issue_en && a_issue_addr != 0) ma_pend[a_issue_addr] <= 1'b1;
      if (a_flush) for (int i = 0; i < 32; i++) ma_pend[i] <= 1'b0;
      if (b_wr_en && b_wr_addr != 0) begin
        mb_reg[b_wr_addr] <= b_wr_data;
        mb_pend[b_wr_addr] <= 1'b0;
      end
      if (b_issue_en && b_issue_addr != 0) mb_pend[b_issue_addr] <= 1'b1;
      if (b_flush) for (int i = 0; i < 16; i++) mb_pend[i] <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic [4:0]  aa;
    logic [3:0]  ba;
    logic [63:0] ed;
    logic        eb, hz;
    int          pc;
    hz = 1'b0;
    for (int p = 0; p < 2; p++) begin
      aa = a_rd_addr[p*5 +: 5];
      if (aa == 0) begin
        ed = '0; eb = 1'b0;
      end else if (a_wr_en && a_wr_addr == aa) begin
        ed = {32'h0, a_wr_data}; eb = 1'b0;
      end else begin
        ed = {32'h0, ma_reg[aa]}; eb = ma_pend[aa];
      end
      check("a_rd_data", {32'h0, a_rd_data[p*32 +: 32]}, ed);
      check("a_rd_busy", {63'h0, a_rd_busy[p]}, {63'h0, eb});
      hz = hz | (a_rd_en[p] & eb);
    end
    check("a_hazard", {63'h0, a_hazard}, {63'h0, hz});
    pc = 0;
    for (int i = 0; i < 32; i++) pc += int'(ma_pend[i]);
    check("a_pending_cnt", {58'h0, a_cnt}, 64'(pc));

    hz = 1'b0;
    for (int p = 0; p < 4; p++) begin
      ba = b_rd_addr[p*4 +: 4];
      if (ba == 0) begin
        ed = '0; eb = 1'b0;
      end else begin
        ed = mb_reg[ba]; eb = mb_pend[ba];
      end
      check("b_rd_data", b_rd_data[p*64 +: 64], ed);
      check("b_rd_busy", {63'h0, b_rd_busy[p]}, {63'h0, eb});
      hz = hz | (b_rd_en[p] & eb);
    end
    check("b_hazard", {63'h0, b_hazard}, {63'h0, hz});
    pc = 0;
    for (int i = 0; i < 16; i++) pc += int'(mb_pend[i]);
    check("b_pending_cnt", {59'h0, b_cnt}, 64'(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rd_addr = '0; a_rd_en = '0; a_issue_en = 0; a_issue_addr = '0;
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_flush = 0;
    b_rd_addr = '0; b_rd_en = '0; b_issue_en = 0; b_issue_addr = '0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_flush = 0;

    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    #3;
    check("reset_cnt", {58'h0, a_cnt}, 64'd0);
    check("reset_data", a_rd_data, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Write x5 and read back via bypass, then from the array
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd0, 5'd5};
    #1 check("wr_bypass_x5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    tick(); a_wr_en = 0;
    #1 check("rd_x5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    check("rd_x0", {32'h0, a_rd_data[63:32]}, 64'h0);
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'h1234; a_rd_addr = {5'd5, 5'd0};
    tick(); a_wr_en = 0;
    #1 check("x0_after_write", {32'h0, a_rd_data[31:0]}, 64'h0);

    // Scoreboard on x7
    a_issue_en = 1; a_issue_addr = 7; a_rd_addr = {5'd0, 5'd7}; a_rd_en = 2'b01;
    #1 check("issue_not_same_cycle", {63'h0, a_rd_busy[0]}, 64'd0);
    tick(); a_issue_en = 0;
    #1 check("x7_busy", {63'h0, a_rd_busy[0]}, 64'd1);
    check("hazard_en", {63'h0, a_hazard}, 64'd1);
    check("cnt_x7", {58'h0, a_cnt}, 64'd1);
    a_rd_en = 2'b00;
    #1 check("hazard_no_en", {63'h0, a_hazard}, 64'd0);
    a_rd_en = 2'b01; a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'h55;
    #1 check("wb_bypass_data", {32'h0, a_rd_data[31:0]}, 64'h55);
    check("wb_bypass_busy", {63'h0, a_rd_busy[0]}, 64'd0);
    tick(); a_wr_en = 0;
    #1 check("cnt_after_wb", {58'h0, a_cnt}, 64'd0);

    // Issue/write-back collision and WAW on x9
    a_issue_en = 1; a_issue_addr = 9; a_rd_addr = {5'd0, 5'd9};
    tick();
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'hAA;
    tick(); a_wr_en = 0;
    #1 check("collide_data", {32'h0, a_rd_data[31:0]}, 64'hAA);
    check("collide_busy", {63'h0, a_rd_busy[0]}, 64'd1);
    check("collide_cnt", {58'h0, a_cnt}, 64'd1);
    tick(); a_issue_en = 0;
    #1 check("waw_cnt", {58'h0, a_cnt}, 64'd1);
    a_wr_en = 1; a_wr_data = 32'hAB;
    tick(); a_wr_en = 0;

    // Fill the scoreboard, then flush with a concurrent issue and write
    a_issue_en = 1;
    for (int r = 1; r < 32; r++) begin
      a_issue_addr = 5'(r);
      tick();
    end
    a_issue_en = 0;
    #1 check("cnt_full", {58'h0, a_cnt}, 64'd31);
    a_flush = 1; a_issue_en = 1; a_issue_addr = 3;
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 32'd7;
    a_rd_addr = {5'd3, 5'd4}; a_rd_en = 2'b11;
    tick(); a_flush = 0; a_issue_en = 0; a_wr_en = 0;
    #1 check("flush_cnt", {58'h0, a_cnt}, 64'd0);
    check("flush_x4", {32'h0, a_rd_data[31:0]}, 64'd7);
    check("flush_busy", {62'h0, a_rd_busy}, 64'd0);
    check("flush_hazard", {63'h0, a_hazard}, 64'd0);

    // Asynchronous reset mid-operation
    a_issue_en = 1; a_issue_addr = 12;
    tick(); a_issue_en = 0; a_rd_addr = {5'd5, 5'd12};
    #1 check("pre_rst_busy", {63'h0, a_rd_busy[0]}, 64'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_cnt", {58'h0, a_cnt}, 64'd0);
    check("rst_busy", {63'h0, a_rd_busy[0]}, 64'd0);
    check("rst_x5", {32'h0, a_rd_data[63:32]}, 64'd0);
    check("rst_hazard", {63'h0, a_hazard}, 64'd0);
    #1 rst_n = 1'b1;
    a_rd_en = '0;
    tick();

    // Non-bypassing instance: same-cycle write-back is not forwarded
    b_issue_en = 1; b_issue_addr = 3; b_rd_addr = {4'd0, 4'd3, 4'd0, 4'd0};
    tick(); b_issue_en = 0;
    b_wr_en = 1; b_wr_addr = 3; b_wr_data = 64'h0123456789ABCDEF;
    #1 check("b_nobypass_data", b_rd_data[128 +: 64], 64'd0);
    check("b_nobypass_busy", {63'h0, b_rd_busy[2]}, 64'd1);
    tick(); b_wr_en = 0;
    #1 check("b_wb_data", b_rd_data[128 +: 64], 64'h0123456789ABCDEF);
    check("b_wb_busy", {63'h0, b_rd_busy[2]}, 64'd0);

    // Random traffic on both instances, checked each cycle by the compare loop
    for (int n = 0; n < 400; n++) begin
      a_issue_en = 1'($urandom_range(0, 1)); a_issue_addr = 5'($urandom);
      a_wr_en = 1'($urandom_range(0, 1)); a_wr_addr = 5'($urandom); a_wr_data = $urandom;
      a_flush = ($urandom_range(0, 15) == 0); a_rd_en = 2'($urandom);
      a_rd_addr = 10'($urandom);
      b_issue_en = 1'($urandom_range(0, 1)); b_issue_addr = 4'($urandom);
      b_wr_en = 1'($urandom_range(0, 1)); b_wr_addr = 4'($urandom);
      b_wr_data = {$urandom, $urandom};
      b_flush = ($urandom_range(0, 15) == 0); b_rd_en = 4'($urandom);
      b_rd_addr = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised RISC-V integer register file with an integrated scoreboard and write-back bypass, sitting between decode/issue and the write-back stage of the core. It provides NUM_RD combinational read ports. Each read port returns data plus a busy flag for registers whose producing instruction has issued but not yet written back. The block raises a hazard signal for the issue stage and keeps a running count of outstanding destinations.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports, legal range 1..4
- BYPASS, 1, 1 = same-cycle write-back data and busy-clear forwarded to read ports; 0 = no forwarding
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_en  in  NUM_RD  port i operand actually needed this cycle
- rd_data  out  NUM_RD*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  out  NUM_RD  port i register has a pending write
- hazard  out  1  |(rd_en & rd_busy)
- issue_en  in  1  mark issue_addr as pending (destination of newly issued instruction)
- issue_addr  in  ADDR_WIDTH  destination being issued
- wr_en  in  1  write-back valid
- wr_addr  in  ADDR_WIDTH  write-back destination
- wr_data  in  DATA_WIDTH  write-back value
- flush  in  1  synchronous clear of all pending bits (pipeline flush); register data untouched
- pending_cnt  out  ADDR_WIDTH+1  number of registers currently pending

## Operation
- State: regs[0..NUM_REGS-1], pending[0..NUM_REGS-1], pending_cnt register.
- Register 0 is hard-wired:
  - it reads 0 and is never busy;
  - writes and issues to address 0 are ignored;
  - regs[0] need not be a flop.
- Write: on clk rise with wr_en and wr_addr != 0, regs[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Issue: on clk rise with issue_en and issue_addr != 0, pending[issue_addr] <= 1.
- Issue and write-back to the same nonzero address in one cycle: data is written and pending ends 1 (the newer issue wins).
- Flush: all pending <= 0 and pending_cnt <= 0.
  - A write in the same cycle still updates regs.
  - An issue in the same cycle is dropped (flush dominates).
- pending_cnt tracks the population of pending bits and must equal popcount(pending) every cycle.
  - Each cycle it changes by +1 (issue to a non-pending register), -1 (write-back clearing a set bit with no re-issue to it), 0, or combinations of these.
  - Issue to an already-pending register (WAW) does not increment.
  - Write-back to a non-pending register does not decrement.
- Read port i, BYPASS=1, a = rd_addr_i:
  - a == 0: data 0, busy 0.
  - else if wr_en and wr_addr == a: data wr_data, busy 0.
  - else: data regs[a], busy pending[a].
- BYPASS=0: data regs[a], busy pending[a] (0 for a == 0), with no forwarding.
- Same-cycle issue never affects rd_busy; it becomes visible the next cycle.
- hazard is combinational from rd_en and rd_busy only.

## Timing
- Reads, rd_busy and hazard are combinational from addresses and current state, with zero latency.
- Writes, issue, flush and pending_cnt update on clk rise, so their effects are visible one cycle later (or same cycle via bypass, BYPASS=1 only).
- Reset is asynchronous on rst_n low:
  - all regs = 0, all pending = 0, pending_cnt = 0;
  - consequently rd_data = 0, rd_busy = 0, hazard = 0 while rst_n is low.
- Reset asserted mid-operation discards all pending state immediately.
- First updates are taken on the first clk rise after rst_n deasserts.
- Multiple read ports at the same address return identical values.
- Maximum pending_cnt = NUM_REGS-1; the counter never wraps.

## Test plan
- Reset: drive regs via writes, assert rst_n=0 asynchronously between edges -> rd_data all 0, pending_cnt 0 immediately.
- Write/read: write x5=0xDEADBEEF, next cycle read port0=x5, port1=x0 -> 0xDEADBEEF, 0; write to x0 of 0x1234 -> x0 still reads 0.
- Scoreboard:
  - issue x7 -> next cycle rd_busy for x7 = 1, hazard=1 with rd_en=1, hazard=0 with rd_en=0, pending_cnt=1;
  - write-back x7=0x55 -> with BYPASS=1 same cycle data 0x55, busy 0; next cycle pending_cnt=0.
- Collisions:
  - issue and write-back x9 same cycle -> x9 data updated, busy stays 1, pending_cnt unchanged from before;
  - re-issue of a pending x9 -> count unchanged.
- Flush: issue x1..x31 over 31 cycles -> pending_cnt=31; flush with simultaneous issue x3 and write x4=7 -> pending_cnt=0, no busy, x4 reads 7.
- Parameter sweep: NUM_RD=4, ADDR_WIDTH=4, DATA_WIDTH=64, BYPASS=0 -> same-cycle write-back returns old value and busy=1; random issue/write/flush traffic against a reference model checks data, busy and pending_cnt==popcount every cycle.
